// File: rtl/ela_mem_arb_if.sv
// Bus bundle between the two requesters, the result-SRAM arbiter and the SRAM.
// slave: arbiter side. master: requester/SRAM side, i.e. the environment.
interface ela_mem_arb_if #(
   parameter int AW = 13,
   parameter int DW = 8
);
   logic          m0_req, m0_we, m0_last, m0_gnt, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_last, m1_gnt, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          mem_ce, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_last,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_last,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_ce, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_last,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_last,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_ce, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/ela_mem_arb.sv
// Two-master burst arbiter for the single-port ELA result SRAM, with registered SRAM port.
// Optional ELA_ARB_FIXED_PRIO_EN: m0 wins ties and is never cut by the MAX_BURST cap.
module ela_mem_arb #(
   parameter int AW        = 13,
   parameter int DW        = 8,
   parameter int MAX_BURST = 128
) (
   input  logic      clk,
   input  logic      rst,
   ela_mem_arb_if.slave bus,
   output logic      busy
);
   localparam int CW     = $clog2(MAX_BURST + 1);
   localparam int STAGES = 1;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t                  state, state_nx;
   logic                    rr, rr_nx;         // 0: ties go to m0
   logic [CW-1:0]           cnt, cnt_nx;
   logic [1:0]              req, we, last, gnt;
   logic [1:0][AW-1:0]      addr;
   logic [1:0][DW-1:0]      wdata;
   logic                    own, acc, o_req, x_req, cap, cap_en, tie_m1, rel;

   logic                    ce_q, we_q;
   logic [AW-1:0]           addr_q;
   logic [DW-1:0]           wdata_q;
   logic [STAGES:0]         vld_pipe, tag_pipe;

   assign req   = {bus.m1_req,   bus.m0_req};
   assign we    = {bus.m1_we,    bus.m0_we};
   assign last  = {bus.m1_last,  bus.m0_last};
   assign addr  = {bus.m1_addr,  bus.m0_addr};
   assign wdata = {bus.m1_wdata, bus.m0_wdata};

   assign own    = (state == OWN1);
   assign gnt[0] = (state == OWN0) && req[0];
   assign gnt[1] = (state == OWN1) && req[1];
   assign acc    = |gnt;
   assign o_req  = req[own];
   assign x_req  = req[~own];
   assign cap    = (cnt == CW'(MAX_BURST - 1));

`ifdef ELA_ARB_FIXED_PRIO_EN
   assign tie_m1 = 1'b0;
   assign cap_en = own;
`else
   assign tie_m1 = rr;
   assign cap_en = 1'b1;
`endif

   // owner gives up on last beat, on dropping req, or when capped with the other waiting
   assign rel = (state != IDLE) &&
                (!o_req || (acc && (last[own] || (cap && cap_en && x_req))));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         rr    <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         rr    <= rr_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      rr_nx    = rr;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (req[0] && (!req[1] || !tie_m1)) state_nx = OWN0;
            else if (req[1])                   state_nx = OWN1;
         end
         default: begin
            if (rel) begin
               state_nx = x_req ? (own ? OWN0 : OWN1) : IDLE;
               rr_nx    = ~own;
               cnt_nx   = '0;
            end else if (acc) begin
               cnt_nx = cap ? '0 : cnt + CW'(1);
            end
         end
      endcase
   end

   // SRAM port and read-return tags; tag is the owner at accept time
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ce_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         ce_q <= acc;
         if (acc) begin
            we_q    <= we[own];
            addr_q  <= addr[own];
            wdata_q <= wdata[own];
         end
         vld_pipe <= {vld_pipe[STAGES-1:0], acc & ~we[own]};
         tag_pipe <= {tag_pipe[STAGES-1:0], own};
      end
   end

   always_comb begin
      busy          = (state != IDLE);
      bus.m0_gnt    = gnt[0];
      bus.m1_gnt    = gnt[1];
      bus.m0_rvalid = vld_pipe[STAGES] & ~tag_pipe[STAGES];
      bus.m1_rvalid = vld_pipe[STAGES] &  tag_pipe[STAGES];
      bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
      bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;
   end

   assign bus.mem_ce    = ce_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
endmodule
